// File: rtl/up_bus_pkg.sv
// Shared definitions for the processor bus memory responder: state encoding,
// default bus widths and the wait-state counter width.
package up_bus_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_WACK = 3'd4
    } state_t;

endpackage

// File: rtl/up_mem_ram.sv
// Single-port synchronous RAM with write enable and a registered, read-enabled
// output; the output register holds its value between reads.
module up_mem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage array is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/up_mem_responder.sv
// Memory-side responder on the multiplexed address/data bus: latches an address
// on ale, serves auto-incrementing reads/writes and acknowledges with mem_re.
module up_mem_responder
    import up_bus_pkg::*;
#(
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int DATA_W      = BUS_DATA_W,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ale,
    input  logic              mem_we,
    input  logic              mem_rd,
    input  logic [DATA_W-1:0] ad_in,
    output logic [DATA_W-1:0] dout,
    output logic              dout_oe,
    output logic              mem_re,
    output logic              busy,
    output logic              err
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              err_n;
    logic              ram_we;
    logic              ram_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            cnt    <= cnt_n;
            err    <= err_n;
        end
    end

    // ale overrides whatever the state decided, including aborting a pending
    // read and replacing the post-response increment.
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        cnt_n   = cnt;
        err_n   = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ale && (mem_we || mem_rd)) begin
                    err_n = 1'b1;
                end
            end
            ST_ADDR: begin
                if (!ale && mem_we) begin
                    ram_we  = 1'b1;
                    err_n   = mem_rd;
                    state_n = ST_WACK;
                end else if (!ale && mem_rd) begin
                    if (WAIT_STATES == 0) begin
                        ram_re  = 1'b1;
                        state_n = ST_RESP;
                    end else begin
                        cnt_n   = CNT_W'(WAIT_STATES);
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!ale) begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        ram_re  = 1'b1;
                        state_n = ST_RESP;
                    end
                end
            end
            ST_RESP, ST_WACK: begin
                addr_n  = addr_q + ADDR_W'(1);
                state_n = ST_ADDR;
            end
            default: state_n = ST_IDLE;
        endcase
        if (ale) begin
            addr_n  = ad_in[ADDR_W-1:0];
            state_n = ST_ADDR;
        end
    end

    assign mem_re  = (state == ST_RESP) || (state == ST_WACK);
    assign dout_oe = (state == ST_RESP);
    assign busy    = (state == ST_WAIT) || (state == ST_RESP) || (state == ST_WACK);

    up_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (ad_in),
        .rdata (dout)
    );

endmodule

// File: tb/tb_up_mem_responder.sv
// Directed bench for up_mem_responder: two instances (1 and 3 wait states),
// a RAM model and a read-data scoreboard.
module tb_up_mem_responder;

    logic       clk;
    logic       rst     [2];
    logic       ale     [2];
    logic       mem_we  [2];
    logic       mem_rd  [2];
    logic [7:0] ad_in   [2];
    logic [7:0] dout    [2];
    logic       dout_oe [2];
    logic       mem_re  [2];
    logic       busy    [2];
    logic       err     [2];

    logic [7:0] model [2][256];
    logic [7:0] maddr [2];
    logic [7:0] sb_q [$];
    int checks;
    int errors;

    up_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(1)) dut_a (
        .clk(clk), .rst(rst[0]), .ale(ale[0]), .mem_we(mem_we[0]), .mem_rd(mem_rd[0]),
        .ad_in(ad_in[0]), .dout(dout[0]), .dout_oe(dout_oe[0]), .mem_re(mem_re[0]),
        .busy(busy[0]), .err(err[0])
    );

    up_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(3)) dut_b (
        .clk(clk), .rst(rst[1]), .ale(ale[1]), .mem_we(mem_we[1]), .mem_rd(mem_rd[1]),
        .ad_in(ad_in[1]), .dout(dout[1]), .dout_oe(dout_oe[1]), .mem_re(mem_re[1]),
        .busy(busy[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst[d] = 1'b0;
    endtask

    task automatic set_addr(input int d, input logic [7:0] a);
        @(negedge clk);
        ale[d]   = 1'b1;
        ad_in[d] = a;
        @(negedge clk);
        ale[d]   = 1'b0;
        maddr[d] = a;
    endtask

    task automatic do_write(input int d, input logic [7:0] data);
        @(negedge clk);
        mem_we[d] = 1'b1;
        ad_in[d]  = data;
        model[d][maddr[d]] = data;
        maddr[d]++;
        @(negedge clk);
        mem_we[d] = 1'b0;
        check_output("wr_mem_re", mem_re[d], 1);
        check_output("wr_dout_oe", dout_oe[d], 0);
        check_output("wr_busy", busy[d], 1);
    endtask

    task automatic do_read(input int d);
        int lat;
        logic [7:0] exp;
        lat = -1;
        @(negedge clk);
        mem_rd[d] = 1'b1;
        sb_q.push_back(model[d][maddr[d]]);
        maddr[d]++;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) mem_rd[d] = 1'b0;
            if (mem_re[d]) begin
                lat = k;
                break;
            end
        end
        check_output("rd_latency", lat, ws_of(d) + 1);
        exp = sb_q.pop_front();
        if (lat > 0) begin
            check_output("rd_dout_oe", dout_oe[d], 1);
            check_output("rd_dout", dout[d], exp);
        end
    endtask

    task automatic watch_no_mem_re(input int d, input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (mem_re[d]) seen = 1'b1;
        end
        check_output(tag, seen, 0);
    endtask

    task automatic apply_stimulus;
        logic [7:0] held;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; ale[d] = 1'b0; mem_we[d] = 1'b0; mem_rd[d] = 1'b0;
            ad_in[d] = 8'h00; maddr[d] = 8'h00;
        end
        do_reset(0);
        do_reset(1);
        check_output("rst_dout", dout[0], 0);
        check_output("rst_dout_oe", dout_oe[0], 0);
        check_output("rst_mem_re", mem_re[0], 0);
        check_output("rst_busy", busy[0], 0);
        check_output("rst_err", err[0], 0);

        // strobe in IDLE
        @(negedge clk);
        mem_rd[0] = 1'b1;
        @(negedge clk);
        mem_rd[0] = 1'b0;
        check_output("idle_err", err[0], 1);
        check_output("idle_mem_re", mem_re[0], 0);
        @(negedge clk);
        check_output("idle_err_pulse", err[0], 0);
        check_output("idle_no_resp", mem_re[0], 0);

        // basic write then read with one wait state
        set_addr(0, 8'h10);
        do_write(0, 8'hA5);
        set_addr(0, 8'h10);
        do_read(0);

        // burst write/read, then prove the pointer ended at 0x23
        set_addr(0, 8'h20);
        do_write(0, 8'h01);
        do_write(0, 8'h02);
        do_write(0, 8'h03);
        set_addr(0, 8'h20);
        do_read(0);
        do_read(0);
        do_read(0);
        do_write(0, 8'h44);
        set_addr(0, 8'h23);
        do_read(0);

        // address wrap
        set_addr(0, 8'hFF);
        do_write(0, 8'h5A);
        do_write(0, 8'hC3);
        set_addr(0, 8'hFF);
        do_read(0);
        do_read(0);
        set_addr(0, 8'h00);
        do_read(0);

        // write and read strobes together
        set_addr(0, 8'h50);
        @(negedge clk);
        mem_we[0] = 1'b1;
        mem_rd[0] = 1'b1;
        ad_in[0]  = 8'h77;
        model[0][8'h50] = 8'h77;
        @(negedge clk);
        mem_we[0] = 1'b0;
        mem_rd[0] = 1'b0;
        check_output("both_mem_re", mem_re[0], 1);
        check_output("both_err", err[0], 1);
        set_addr(0, 8'h50);
        do_read(0);

        // reset while a read is waiting
        set_addr(0, 8'h10);
        @(negedge clk);
        mem_rd[0] = 1'b1;
        @(negedge clk);
        mem_rd[0] = 1'b0;
        check_output("mid_busy", busy[0], 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check_output("mid_dout", dout[0], 0);
        check_output("mid_dout_oe", dout_oe[0], 0);
        check_output("mid_mem_re", mem_re[0], 0);
        check_output("mid_busy_clr", busy[0], 0);
        check_output("mid_err", err[0], 0);
        watch_no_mem_re(0, 6, "mid_no_mem_re");
        @(negedge clk);
        mem_we[0] = 1'b1;
        @(negedge clk);
        mem_we[0] = 1'b0;
        check_output("mid_idle_err", err[0], 1);
        check_output("mid_idle_mem_re", mem_re[0], 0);

        // three wait states, then abort by ale
        set_addr(1, 8'h30);
        do_write(1, 8'h99);
        set_addr(1, 8'h30);
        do_read(1);
        held = 8'h99;
        set_addr(1, 8'h30);
        @(negedge clk);
        mem_rd[1] = 1'b1;
        @(negedge clk);
        mem_rd[1] = 1'b0;
        check_output("abort_busy_wait", busy[1], 1);
        ale[1]   = 1'b1;
        ad_in[1] = 8'h40;
        @(negedge clk);
        ale[1]   = 1'b0;
        maddr[1] = 8'h40;
        check_output("abort_busy", busy[1], 0);
        watch_no_mem_re(1, 6, "abort_no_mem_re");
        check_output("abort_dout", dout[1], held);
        do_write(1, 8'h66);
        set_addr(1, 8'h40);
        do_read(1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        apply_stimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
